// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and helpers for the sequential ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MUL  = 4'd10,
        OP_DIVU = 4'd11,
        OP_REMU = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative MUL / DIVU / REMU datapath: one shift-add or restoring-divide step per enabled cycle.
module alu_md_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             start,
    input  logic             step,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res
);

    logic [3:0]       op_q;
    logic [WIDTH:0]   acc_q, acc_n;     // product accumulator or partial remainder
    logic [WIDTH-1:0] opnd_q, opnd_n;   // multiplicand or divisor
    logic [WIDTH-1:0] quo_q, quo_n;     // multiplier or dividend/quotient
    logic [WIDTH:0]   rsh, trial;

    always_comb begin
        acc_n  = acc_q;
        opnd_n = opnd_q;
        quo_n  = quo_q;
        rsh    = {acc_q[WIDTH-1:0], quo_q[WIDTH-1]};
        trial  = rsh - {1'b0, opnd_q};
        if (op_q == OP_MUL) begin
            acc_n  = {1'b0, acc_q[WIDTH-1:0] + (quo_q[0] ? opnd_q : '0)};
            opnd_n = opnd_q << 1;
            quo_n  = quo_q >> 1;
        end else if (rsh >= {1'b0, opnd_q}) begin
            acc_n = trial;
            quo_n = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_n = rsh;
            quo_n = {quo_q[WIDTH-2:0], 1'b0};
        end
        // Result as it stands after this step; the parent loads it on the final one.
        res = (op_q == OP_DIVU) ? quo_n : acc_n[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (start) begin
            op_q   <= op;
            acc_q  <= '0;
            opnd_q <= b;
            quo_q  <= a;
        end else if (step) begin
            acc_q  <= acc_n;
            opnd_q <= opnd_n;
            quo_q  <= quo_n;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with single-cycle ops and an iterative multiply/divide extension.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q;
    logic [WIDTH-1:0] sc_res, md_res;
    logic [SHW-1:0]   sh;
    logic             accept, last, load_sc;

    assign accept  = in_valid && in_ready;
    assign last    = (state_q == S_RUN) && (cnt_q == SHW'(WIDTH - 1));
    assign load_sc = accept && !is_multicycle(op);
    assign sh      = src_b[SHW-1:0];

    always_comb begin
        sc_res = '0;
        case (op)
            OP_ADD:  sc_res = src_a + src_b;
            OP_SUB:  sc_res = src_a - src_b;
            OP_AND:  sc_res = src_a & src_b;
            OP_OR:   sc_res = src_a | src_b;
            OP_XOR:  sc_res = src_a ^ src_b;
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
            OP_SLL:  sc_res = src_a << sh;
            OP_SRL:  sc_res = src_a >> sh;
            OP_SRA:  sc_res = WIDTH'($signed(src_a) >>> sh);
            default: sc_res = '0;   // illegal codes yield zero; MUL/DIVU/REMU never load from here
        endcase
    end

    alu_md_iter #(.WIDTH(WIDTH)) u_md (
        .clk   (clk),
        .start (accept && is_multicycle(op)),
        .step  (state_q == S_RUN),
        .op    (op),
        .a     (src_a),
        .b     (src_b),
        .res   (md_res)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) state_d = is_multicycle(op) ? S_RUN : S_DONE;
                else        state_d = S_IDLE;
            end
            S_RUN:   if (last) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q != S_RUN);
        busy     = (state_q == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            result    <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= load_sc || last;
            if (accept)                cnt_q <= '0;
            else if (state_q == S_RUN) cnt_q <= cnt_q + 1'b1;
            if (load_sc) begin
                result <= sc_res;
                zero   <= (sc_res == '0);
            end else if (last) begin
                result <= md_res;
                zero   <= (md_res == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (WIDTH = 32) with hand-computed expectations.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .out_valid (out_valid),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    // Single-cycle issue: after return the output cycle for this op is current.
    task automatic sc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Multi-cycle issue: counts cycles to out_valid and cycles with in_ready low.
    task automatic mc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                      input bit inject, output logic [31:0] res, output int n, output int low);
        @(negedge clk);
        in_valid = 1'b1; op = o; src_a = a; src_b = b;
        n = 0; low = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            n++;
            if (!in_ready) low++;
            if (inject && n == 5) begin
                in_valid = 1'b1; op = 4'd0; src_a = 32'd1; src_b = 32'd1;
            end
        end while (!out_valid && n < 100);
        in_valid = 1'b0;
        res = result;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (result !== 32'h0) $display("FAIL reset_result got %h exp 0", result); else n_pass++;
        n_chk++; if (zero !== 1'b1) $display("FAIL reset_zero got %b exp 1", zero); else n_pass++;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
        n_chk++; if (busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_busy_ready got %b/%b exp 0/1", busy, in_ready); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_add_sub;
        sc(4'd0, 32'h7FFF_FFFF, 32'h1);
        n_chk++; if (out_valid !== 1'b1 || result !== 32'h8000_0000 || zero !== 1'b0)
            $display("FAIL add_ovf got v%b %h z%b exp v1 80000000 z0", out_valid, result, zero); else n_pass++;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0 || result !== 32'h8000_0000)
            $display("FAIL add_hold got v%b %h exp v0 80000000", out_valid, result); else n_pass++;
        sc(4'd1, 32'd5, 32'd5);
        n_chk++; if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1)
            $display("FAIL sub_zero got v%b %h z%b exp v1 0 z1", out_valid, result, zero); else n_pass++;
    endtask

    task automatic test_cmp_shift;
        sc(4'd5, 32'hFFFF_FFFF, 32'h1);
        n_chk++; if (result !== 32'h1) $display("FAIL slt got %h exp 1", result); else n_pass++;
        sc(4'd6, 32'hFFFF_FFFF, 32'h1);
        n_chk++; if (result !== 32'h0 || zero !== 1'b1)
            $display("FAIL sltu got %h z%b exp 0 z1", result, zero); else n_pass++;
        sc(4'd9, 32'h8000_0000, 32'h24);
        n_chk++; if (result !== 32'hF800_0000) $display("FAIL sra got %h exp f8000000", result); else n_pass++;
        sc(4'd8, 32'h8000_0000, 32'h21);
        n_chk++; if (result !== 32'h4000_0000) $display("FAIL srl got %h exp 40000000", result); else n_pass++;
        sc(4'd7, 32'h0000_0003, 32'h1F);
        n_chk++; if (result !== 32'h8000_0000) $display("FAIL sll got %h exp 80000000", result); else n_pass++;
    endtask

    task automatic test_mul;
        logic [31:0] r;
        int n, low;
        mc(4'd10, 32'hFFFF_FFFF, 32'd3, 1'b1, r, n, low);
        n_chk++; if (n !== 33) $display("FAIL mul_latency got %0d exp 33", n); else n_pass++;
        n_chk++; if (low !== 32) $display("FAIL mul_ready_low got %0d exp 32", low); else n_pass++;
        n_chk++; if (r !== 32'hFFFF_FFFD) $display("FAIL mul_result got %h exp fffffffd", r); else n_pass++;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0 || result !== 32'hFFFF_FFFD)
            $display("FAIL mul_no_queue got v%b %h exp v0 fffffffd", out_valid, result); else n_pass++;
    endtask

    task automatic test_div;
        logic [31:0] r;
        int n, low;
        mc(4'd11, 32'd100, 32'd7, 1'b0, r, n, low);
        n_chk++; if (r !== 32'd14 || n !== 33) $display("FAIL divu got %h n%0d exp e n33", r, n); else n_pass++;
        mc(4'd12, 32'd100, 32'd7, 1'b0, r, n, low);
        n_chk++; if (r !== 32'd2) $display("FAIL remu got %h exp 2", r); else n_pass++;
        mc(4'd11, 32'hDEAD_BEEF, 32'd0, 1'b0, r, n, low);
        n_chk++; if (r !== 32'hFFFF_FFFF || n !== 33)
            $display("FAIL divu_by0 got %h n%0d exp ffffffff n33", r, n); else n_pass++;
        mc(4'd12, 32'h1234, 32'd0, 1'b0, r, n, low);
        n_chk++; if (r !== 32'h1234) $display("FAIL remu_by0 got %h exp 1234", r); else n_pass++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        in_valid = 1'b1; op = 4'd0; src_a = 32'd10; src_b = 32'd20;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1 || result !== 32'd30)
            $display("FAIL b2b_add got v%b %h exp v1 1e", out_valid, result); else n_pass++;
        op = 4'd4; src_a = 32'hF0F0_F0F0; src_b = 32'hFF00_FF00;
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b1 || result !== 32'h0FF0_0FF0)
            $display("FAIL b2b_xor got v%b %h exp v1 0ff00ff0", out_valid, result); else n_pass++;
        op = 4'd3; src_a = 32'h0000_00A0; src_b = 32'h0000_000B;
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1 || result !== 32'h0000_00AB)
            $display("FAIL b2b_or got v%b %h exp v1 ab", out_valid, result); else n_pass++;
        sc(4'd15, 32'h1234_5678, 32'h1);
        n_chk++; if (out_valid !== 1'b1 || result !== 32'h0 || zero !== 1'b1)
            $display("FAIL illegal got v%b %h z%b exp v1 0 z1", out_valid, result, zero); else n_pass++;
    endtask

    task automatic test_reset_mid_run;
        bit seen;
        sc(4'd0, 32'd3, 32'd4);
        n_chk++; if (result !== 32'd7) $display("FAIL pre_rst_add got %h exp 7", result); else n_pass++;
        @(negedge clk);
        in_valid = 1'b1; op = 4'd11; src_a = 32'd1000; src_b = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1 || busy !== 1'b0 || result !== 32'h0 || zero !== 1'b1)
            $display("FAIL rst_mid_run got rdy%b busy%b %h z%b exp 1 0 0 1", in_ready, busy, result, zero);
        else n_pass++;
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL rst_abort_valid got %b exp 0", seen); else n_pass++;
        sc(4'd0, 32'd2, 32'd3);
        n_chk++; if (out_valid !== 1'b1 || result !== 32'd5)
            $display("FAIL post_rst_add got v%b %h exp v1 5", out_valid, result); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_add_sub;
        test_cmp_shift;
        test_mul;
        test_div;
        test_back_to_back;
        test_reset_mid_run;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
